and_gate: RTL and testbench
===========================

AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the high-cycle counter (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port a, input, 1 bit: first AND operand.
REQ-005 The block SHALL have port b, input, 1 bit: second AND operand.
REQ-006 The block SHALL have port c, output, 1 bit: combinational a AND b.
REQ-007 The block SHALL have port c_q, output, 1 bit: c registered on clk.
REQ-008 The block SHALL have port combo_seen, output, 4 bits: sticky flag per input combination, index = {b,a}.
REQ-009 The block SHALL have port all_seen, output, 1 bit: high when all four combo_seen bits are set.
REQ-010 The block SHALL have port high_count, output, CNT_W bits: saturating count of clock edges sampled with c=1.
REQ-011 Instantiation SHALL be by named port connection; a, b, c keep the meaning above.

Function
REQ-012 c SHALL equal a AND b at all times, with zero latency and no dependence on clk or rst_n.
REQ-013 With inputs changed before a rising edge, c SHALL already be valid at that edge; truth table: 00->0, 10->0, 01->0, 11->1 (a,b -> c).
REQ-014 c_q SHALL take the value of (a AND b) at each rising clk edge, so c_q has 1-cycle latency.
REQ-015 At each rising edge, combo_seen[{b,a}] SHALL be set to 1; set bits remain 1 until reset.
REQ-016 all_seen SHALL be the combinational AND of the four combo_seen bits.
REQ-017 At each rising edge with c=1, high_count SHALL increment by 1.
REQ-018 high_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 At rising edges with c=0, high_count SHALL hold its value.
REQ-020 X or Z on a or b SHALL NOT be treated as a valid combination; synthesis semantics apply.

Reset
REQ-021 While rst_n=0, c_q, combo_seen and high_count SHALL be forced to 0 immediately, without waiting for clk.
REQ-022 While rst_n=0, all_seen SHALL be 0.
REQ-023 c SHALL remain a AND b during reset.
REQ-024 Registers SHALL first update on the first rising clk edge after rst_n returns high.
REQ-025 Reset asserted mid-operation SHALL discard all accumulated combo_seen and high_count state.

Verification
REQ-026 Sweep: {b,a} = 00, 01, 10, 11 applied one per cycle, sampled at posedge -> c = 0, 0, 0, 1; c_q lags by one cycle.
REQ-027 After the full sweep -> combo_seen = 4'b1111, all_seen = 1, high_count = 1.
REQ-028 Hold a=b=1 for 300 cycles with CNT_W=8 -> high_count stops at 255 and stays there.
REQ-029 Assert rst_n=0 between clock edges after activity -> c_q, combo_seen, high_count and all_seen become 0 before the next edge; c still tracks a AND b.
REQ-030 Only combinations 00 and 11 applied -> combo_seen = 4'b1001, all_seen = 0.
REQ-031 Toggle a and b between edges without a clock edge -> c follows combinationally; no register changes.

Source files
------------

// File: rtl/and_gate.sv
// and_gate: two-input AND with a registered copy of the result, sticky
// coverage flags for each {b,a} input combination, and a saturating
// count of clock edges on which the AND output was high.
module and_gate #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  output logic             c,
  output logic             c_q,
  output logic [3:0]       combo_seen,
  output logic             all_seen,
  output logic [CNT_W-1:0] high_count
);

  logic             c_reg_q;
  logic             c_reg_d;
  logic [3:0]       combo_q;
  logic [3:0]       combo_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       combo_idx;

  // The AND itself: purely combinational, independent of clk and rst_n.
  assign c = a & b;

  assign combo_idx = {b, a};

  // Next-state logic: capture c, mark the current combination, bump the
  // counter when c is high unless it already sits at its all-ones ceiling.
  always_comb begin
    c_reg_d = c;
    combo_d = combo_q | (4'b0001 << combo_idx);
    count_d = count_q;
    if (c && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // State registers; asynchronous reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg_q <= 1'b0;
      combo_q <= 4'b0000;
      count_q <= '0;
    end else begin
      c_reg_q <= c_reg_d;
      combo_q <= combo_d;
      count_q <= count_d;
    end
  end

  // all_seen falls out of the cleared flags during reset with no extra gating.
  assign c_q        = c_reg_q;
  assign combo_seen = combo_q;
  assign all_seen   = &combo_q;
  assign high_count = count_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed testbench for and_gate with CNT_W = 8.
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge.
module tb_and_gate;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             a;
  logic             b;
  logic             c;
  logic             c_q;
  logic [3:0]       combo_seen;
  logic             all_seen;
  logic [CNT_W-1:0] high_count;

  int n_tests;
  int n_fail;

  // Bench reference state.
  logic [3:0] exp_combo;
  int         exp_cnt;
  logic       exp_cq;

  and_gate #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .c          (c),
    .c_q        (c_q),
    .combo_seen (combo_seen),
    .all_seen   (all_seen),
    .high_count (high_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model update for one rising edge with current a, b.
  task automatic model_edge();
    logic [1:0] idx;
    idx = {b, a};
    exp_cq = a & b;
    exp_combo[idx] = 1'b1;
    if ((a & b) && exp_cnt < 255) exp_cnt++;
  endtask

  task automatic model_reset();
    exp_cq    = 1'b0;
    exp_combo = 4'b0000;
    exp_cnt   = 0;
  endtask

  // Drive on negedge, check c immediately, clock once, check registers.
  task automatic drive_cycle(input logic av, input logic bv, input logic exp_c, input string tag);
    @(negedge clk);
    a = av;
    b = bv;
    #1;
    check_eq({tag, "_c"}, {31'd0, c}, {31'd0, exp_c});
    check_eq({tag, "_cq_lag"}, {31'd0, c_q}, {31'd0, exp_cq});
    @(posedge clk);
    model_edge();
    #1;
    check_eq({tag, "_cq"}, {31'd0, c_q}, {31'd0, exp_cq});
    check_eq({tag, "_combo"}, {28'd0, combo_seen}, {28'd0, exp_combo});
    check_eq({tag, "_cnt"}, {24'd0, high_count}, exp_cnt);
  endtask

  task automatic check_regs(input string tag);
    check_eq({tag, "_cq"}, {31'd0, c_q}, {31'd0, exp_cq});
    check_eq({tag, "_combo"}, {28'd0, combo_seen}, {28'd0, exp_combo});
    check_eq({tag, "_all"}, {31'd0, all_seen}, {31'd0, &exp_combo});
    check_eq({tag, "_cnt"}, {24'd0, high_count}, exp_cnt);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    a = 1'b1;
    b = 1'b1;
    model_reset();

    // Reset state; c keeps tracking a & b while in reset.
    @(posedge clk);
    #1;
    check_regs("reset");
    check_eq("reset_c11", {31'd0, c}, 32'd1);
    a = 1'b0;
    #1;
    check_eq("reset_c01", {31'd0, c}, 32'd0);
    b = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;

    // Sweep {b,a} = 00, 01, 10, 11.
    drive_cycle(1'b0, 1'b0, 1'b0, "sw00");
    drive_cycle(1'b1, 1'b0, 1'b0, "sw01");
    drive_cycle(1'b0, 1'b1, 1'b0, "sw10");
    drive_cycle(1'b1, 1'b1, 1'b1, "sw11");
    check_eq("sweep_combo", {28'd0, combo_seen}, 32'hF);
    check_eq("sweep_all", {31'd0, all_seen}, 32'd1);
    check_eq("sweep_cnt", {24'd0, high_count}, 32'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, "after11");

    // Toggle inputs between edges: c follows, registers hold.
    @(negedge clk);
    a = 1'b1; b = 1'b1; #1;
    check_eq("tog_c11", {31'd0, c}, 32'd1);
    check_regs("tog1");
    a = 1'b0; #1;
    check_eq("tog_c10", {31'd0, c}, 32'd0);
    a = 1'b1; #1;
    check_eq("tog_c11b", {31'd0, c}, 32'd1);
    b = 1'b0; #1;
    check_eq("tog_c01", {31'd0, c}, 32'd0);
    check_regs("tog2");

    // Build up more count, then reset asynchronously between edges.
    drive_cycle(1'b1, 1'b1, 1'b1, "pre_rst1");
    drive_cycle(1'b1, 1'b1, 1'b1, "pre_rst2");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("midrst");
    check_eq("midrst_c11", {31'd0, c}, 32'd1);
    a = 1'b0; #1;
    check_eq("midrst_c01", {31'd0, c}, 32'd0);
    @(posedge clk);
    #1;
    check_regs("midrst_hold");
    @(negedge clk);
    b = 1'b0;
    rst_n = 1'b1;

    // Only 00 and 11 applied.
    drive_cycle(1'b0, 1'b0, 1'b0, "p00a");
    drive_cycle(1'b1, 1'b1, 1'b1, "p11a");
    drive_cycle(1'b0, 1'b0, 1'b0, "p00b");
    drive_cycle(1'b1, 1'b1, 1'b1, "p11b");
    check_eq("partial_combo", {28'd0, combo_seen}, 32'h9);
    check_eq("partial_all", {31'd0, all_seen}, 32'd0);
    check_eq("partial_cnt", {24'd0, high_count}, 32'd2);

    // Saturation: hold a=b=1 for 300 cycles.
    @(negedge clk);
    a = 1'b1;
    b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      model_edge();
      #1;
      check_eq("sat_cnt", {24'd0, high_count}, exp_cnt);
    end
    check_eq("sat_final", {24'd0, high_count}, 32'd255);
    drive_cycle(1'b0, 1'b1, 1'b0, "sat_drop");
    check_eq("sat_hold", {24'd0, high_count}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
